// File: rtl/obj_stats_sweeper_pkg.sv
// Shared widths, FSM encoding and record layout for the object statistics sweeper.
package obj_stats_sweeper_pkg;

  localparam int unsigned LBL_WIDTH = 8;
  localparam int unsigned LOC_SIZE  = 16;

  typedef enum logic [2:0] {
    OSS_IDLE    = 3'd0,
    OSS_ISSUE   = 3'd1,
    OSS_WAIT    = 3'd2,
    OSS_CAPTURE = 3'd3,
    OSS_DRAIN   = 3'd4
  } oss_state_e;

  typedef struct packed {
    logic [LBL_WIDTH-1:0] id;
    logic [LOC_SIZE-1:0]  area;
    logic [LOC_SIZE-1:0]  x;
    logic [LOC_SIZE-1:0]  y;
    logic [LOC_SIZE-1:0]  m02;
    logic [LOC_SIZE-1:0]  m11;
    logic [LOC_SIZE-1:0]  m20;
  } obj_rec_t;

  localparam int unsigned REC_DW = $bits(obj_rec_t);

endpackage

// File: rtl/obj_stats_sweeper_if.sv
// Record stream from the sweeper to the host: valid/ready plus the captured record.
interface obj_stats_sweeper_if;
  import obj_stats_sweeper_pkg::*;

  logic     rec_valid;
  logic     rec_ready;
  obj_rec_t rec;

  modport master (output rec_valid, output rec, input rec_ready);
  modport slave  (input rec_valid, input rec, output rec_ready);
endinterface

// File: rtl/obj_stats_sweeper_fifo.sv
// obj_record_fifo: synchronous first-word-fall-through FIFO; full/empty decode from pointers.
module obj_record_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/obj_stats_sweeper.sv
// Sweeps label stats after each frame into a record FIFO drained by the host.
// Optional OBJ_STATS_AREA_FILTER_EN: labels with area below i_min_area are consumed but not queued.
module obj_stats_sweeper
  import obj_stats_sweeper_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_frame_done,
  input  logic [LBL_WIDTH-1:0] i_num_labels,
  input  logic [LOC_SIZE-1:0]  i_obj_area,
  input  logic [LOC_SIZE-1:0]  i_obj_x,
  input  logic [LOC_SIZE-1:0]  i_obj_y,
  input  logic [LOC_SIZE-1:0]  i_obj_m02,
  input  logic [LOC_SIZE-1:0]  i_obj_m11,
  input  logic [LOC_SIZE-1:0]  i_obj_m20,
  input  logic [LOC_SIZE-1:0]  i_min_area,
  output logic [LBL_WIDTH-1:0] o_obj_id,
  output logic                 o_busy,
  output logic                 o_sweep_done,
  output logic [7:0]           o_frames_dropped,
  obj_stats_sweeper_if.master  rec_if
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  oss_state_e           r_state,  w_state_n;
  logic [LBL_WIDTH-1:0] r_obj_id, w_obj_id_n;
  logic [LBL_WIDTH-1:0] r_n,      w_n_n;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_n;
  logic                 r_sweep_done, w_sweep_done_n;
  logic [7:0]           r_frames_dropped;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_skip;
  obj_rec_t             w_din;
  obj_rec_t             w_dout;

`ifdef OBJ_STATS_AREA_FILTER_EN
  assign w_skip = (i_obj_area < i_min_area);
`else
  logic w_unused_min_area;
  assign w_unused_min_area = ^i_min_area;
  assign w_skip            = 1'b0;
`endif

  assign w_din = '{id: r_obj_id, area: i_obj_area, x: i_obj_x, y: i_obj_y,
                   m02: i_obj_m02, m11: i_obj_m11, m20: i_obj_m20};

  obj_record_fifo #(
    .AW (FIFO_AW),
    .DW (REC_DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop            = rec_if.rec_ready & ~w_empty;
  assign rec_if.rec_valid = ~w_empty;
  assign rec_if.rec       = w_dout;
  assign o_obj_id         = r_obj_id;
  assign o_sweep_done     = r_sweep_done;
  assign o_frames_dropped = r_frames_dropped;
  assign o_busy           = (r_state != OSS_IDLE) | ~w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= OSS_IDLE;
      r_obj_id     <= '0;
      r_n          <= '0;
      r_cnt        <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_obj_id     <= w_obj_id_n;
      r_n          <= w_n_n;
      r_cnt        <= w_cnt_n;
      r_sweep_done <= w_sweep_done_n;
    end
  end

  // Label sequencing: ISSUE + (RD_LAT-1) WAIT cycles + CAPTURE per label.
  always_comb begin
    w_state_n      = r_state;
    w_obj_id_n     = r_obj_id;
    w_n_n          = r_n;
    w_cnt_n        = r_cnt;
    w_sweep_done_n = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      OSS_IDLE: begin
        if (i_frame_done) begin
          w_n_n = i_num_labels;
          if (i_num_labels == '0) begin
            w_state_n = OSS_DRAIN;
          end else begin
            w_obj_id_n = LBL_WIDTH'(1);
            w_state_n  = OSS_ISSUE;
          end
        end
      end
      OSS_ISSUE: begin
        w_cnt_n   = CNT_W'(RD_LAT - 1);
        w_state_n = (RD_LAT > 1) ? OSS_WAIT : OSS_CAPTURE;
      end
      OSS_WAIT: begin
        w_cnt_n = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_n = OSS_CAPTURE;
        end
      end
      OSS_CAPTURE: begin
        // A skipped label never needs FIFO space, so it must not stall on full.
        if (w_skip || !w_full) begin
          w_push = ~w_skip;
          if (r_obj_id == r_n) begin
            w_state_n = OSS_DRAIN;
          end else begin
            w_obj_id_n = r_obj_id + LBL_WIDTH'(1);
            w_state_n  = OSS_ISSUE;
          end
        end
      end
      OSS_DRAIN: begin
        if (w_empty) begin
          w_sweep_done_n = 1'b1;
          w_obj_id_n     = '0;
          w_state_n      = OSS_IDLE;
        end
      end
      default: begin
        w_state_n = OSS_IDLE;
      end
    endcase
  end

  // Frames arriving while not idle are dropped and counted, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frames_dropped <= '0;
    end else if (i_frame_done && (r_state != OSS_IDLE) && (r_frames_dropped != 8'hFF)) begin
      r_frames_dropped <= r_frames_dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_obj_stats_sweeper.sv
// Randomised self-checking bench for obj_stats_sweeper with a label-stats store model.
module tb_obj_stats_sweeper;
  import obj_stats_sweeper_pkg::*;

  localparam int unsigned FIFO_AW = 4;
  localparam int unsigned RD_LAT  = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 i_frame_done;
  logic [LBL_WIDTH-1:0] i_num_labels;
  logic [LOC_SIZE-1:0]  i_obj_area, i_obj_x, i_obj_y, i_obj_m02, i_obj_m11, i_obj_m20;
  logic [LOC_SIZE-1:0]  i_min_area;
  logic [LBL_WIDTH-1:0] o_obj_id;
  logic                 o_busy;
  logic                 o_sweep_done;
  logic [7:0]           o_frames_dropped;

  obj_stats_sweeper_if rif ();

  obj_stats_sweeper #(.FIFO_AW(FIFO_AW), .RD_LAT(RD_LAT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_frame_done     (i_frame_done),
    .i_num_labels     (i_num_labels),
    .i_obj_area       (i_obj_area),
    .i_obj_x          (i_obj_x),
    .i_obj_y          (i_obj_y),
    .i_obj_m02        (i_obj_m02),
    .i_obj_m11        (i_obj_m11),
    .i_obj_m20        (i_obj_m20),
    .i_min_area       (i_min_area),
    .o_obj_id         (o_obj_id),
    .o_busy           (o_busy),
    .o_sweep_done     (o_sweep_done),
    .o_frames_dropped (o_frames_dropped),
    .rec_if           (rif)
  );

  always #5 clk = ~clk;

  // Stats store: output reflects obj_id as it was RD_LAT cycles earlier.
  obj_rec_t             stats_tab [256];
  logic [LBL_WIDTH-1:0] id_d1, id_d2;
  always_ff @(posedge clk) begin
    id_d1 <= o_obj_id;
    id_d2 <= id_d1;
  end
  assign i_obj_area = stats_tab[id_d2].area;
  assign i_obj_x    = stats_tab[id_d2].x;
  assign i_obj_y    = stats_tab[id_d2].y;
  assign i_obj_m02  = stats_tab[id_d2].m02;
  assign i_obj_m11  = stats_tab[id_d2].m11;
  assign i_obj_m20  = stats_tab[id_d2].m20;

  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  int       fd_cyc = 0;
  int       last_pop_cyc = 0;
  int       sweep_done_cyc = 0;
  int       sweeps_seen = 0;
  int       pop_count = 0;
  obj_rec_t exp_q [$];
  obj_rec_t last_rec;
  obj_rec_t prev_rec;
  bit       prev_stall = 1'b0;
  bit       prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input obj_rec_t act, input obj_rec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit kept(input obj_rec_t s);
`ifdef OBJ_STATS_AREA_FILTER_EN
    return s.area >= i_min_area;
`else
    return 1'b1;
`endif
  endfunction

  // Compare process: every record popped must be the next expected label's stats.
  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (i_frame_done) fd_cyc = cyc;
      if (rif.rec_valid) chk("busy_with_record", o_busy, 1);
      if (prev_stall) begin
        chk("head_held_valid", rif.rec_valid, 1);
        chk_rec("head_held_data", rif.rec, prev_rec);
      end
      if (rif.rec_valid && rif.rec_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_record actual=%h required=none", rif.rec);
        end else begin
          if (rif.rec !== exp_q[0]) begin
            failures++;
            $display("FAIL record actual=%h required=%h", rif.rec, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        last_pop_cyc = cyc;
        last_rec     = rif.rec;
        pop_count++;
      end
      if (o_sweep_done) begin
        chk("records_left_at_done", exp_q.size(), 0);
        chk("busy_at_done", o_busy, 0);
        chk("busy_before_done", prev_busy, 1);
        exp_q.delete();
        sweep_done_cyc = cyc;
        sweeps_seen++;
      end
      prev_busy  = o_busy;
      prev_stall = rif.rec_valid && !rif.rec_ready;
      prev_rec   = rif.rec;
    end else begin
      prev_busy  = 1'b0;
      prev_stall = 1'b0;
    end
  end

  task automatic rand_stats();
    for (int i = 0; i < 256; i++) begin
      stats_tab[i].id   = '0;
      stats_tab[i].area = LOC_SIZE'($urandom);
      stats_tab[i].x    = LOC_SIZE'($urandom);
      stats_tab[i].y    = LOC_SIZE'($urandom);
      stats_tab[i].m02  = LOC_SIZE'($urandom);
      stats_tab[i].m11  = LOC_SIZE'($urandom);
      stats_tab[i].m20  = LOC_SIZE'($urandom);
    end
  endtask

  task automatic start_frame(input int n);
    for (int i = 1; i <= n; i++) begin
      if (kept(stats_tab[i])) begin
        obj_rec_t r;
        r    = stats_tab[i];
        r.id = LBL_WIDTH'(i);
        exp_q.push_back(r);
      end
    end
    i_num_labels = LBL_WIDTH'(n);
    i_frame_done = 1'b1;
    @(posedge clk);
    #1 i_frame_done = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int start;
    start = sweeps_seen;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      #1;
      if (rnd) rif.rec_ready = 1'($urandom_range(0, 1));
      if (sweeps_seen != start) return;
    end
    chk("sweep_done_timeout", sweeps_seen - start, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    reset_n       = 1'b0;
    i_frame_done  = 1'b0;
    i_num_labels  = '0;
    i_min_area    = '0;
    rif.rec_ready = 1'b1;
    rand_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rif.rec_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_obj_id", o_obj_id, 0);
    chk("rst_sweep_done", o_sweep_done, 0);
    chk("rst_dropped", o_frames_dropped, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Three labels with recognisable stats, host always ready.
    for (int i = 0; i < 256; i++) begin
      stats_tab[i] = '{id: '0, area: LOC_SIZE'(100 + i), x: LOC_SIZE'(200 + i),
                       y: LOC_SIZE'(300 + i), m02: LOC_SIZE'(400 + i),
                       m11: LOC_SIZE'(500 + i), m20: LOC_SIZE'(600 + i)};
    end
    i_min_area = '0;
    start_frame(3);
    wait_done(1'b0);
    chk("t1_last_id", last_rec.id, 3);
    chk("t1_last_area", last_rec.area, 103);
    chk("t1_last_m20", last_rec.m20, 603);
    chk("t1_done_after_pop", sweep_done_cyc - last_pop_cyc, 2);
    chk("t1_sweep_latency", sweep_done_cyc - fd_cyc, 12);

    // Empty frame.
    pc = pop_count;
    start_frame(0);
    chk("t2_obj_id_during", o_obj_id, 0);
    wait_done(1'b0);
    chk("t2_done_within_2", (sweep_done_cyc - fd_cyc) <= 2, 1);
    chk("t2_no_records", pop_count - pc, 0);
    chk("t2_obj_id_after", o_obj_id, 0);

    // Backpressure until the FIFO is full.
    rand_stats();
    rif.rec_ready = 1'b0;
    pc = pop_count;
    start_frame(40);
    repeat (80) @(posedge clk);
    #1;
    chk("t3_obj_id_frozen_a", o_obj_id, 17);
    repeat (30) @(posedge clk);
    #1;
    chk("t3_obj_id_frozen_b", o_obj_id, 17);
    chk("t3_valid_while_full", rif.rec_valid, 1);
    rif.rec_ready = 1'b1;
    wait_done(1'b0);
    chk("t3_record_count", pop_count - pc, 40);

    // Random frames with random host backpressure, including the largest label count.
    for (int f = 0; f < 7; f++) begin
      int n;
      rand_stats();
      i_min_area = LOC_SIZE'($urandom);
      n = (f == 6) ? 255 : int'($urandom_range(1, 40));
      start_frame(n);
      wait_done(1'b1);
      rif.rec_ready = 1'b1;
      @(posedge clk);
      #1;
    end

    // Area filter pattern.
    rand_stats();
    stats_tab[1].area = 16'd5;
    stats_tab[2].area = 16'd12;
    stats_tab[3].area = 16'd9;
    stats_tab[4].area = 16'd30;
    i_min_area = 16'd10;
    pc = pop_count;
    start_frame(4);
    wait_done(1'b0);
`ifdef OBJ_STATS_AREA_FILTER_EN
    chk("t6_record_count", pop_count - pc, 2);
`else
    chk("t6_record_count", pop_count - pc, 4);
`endif
    chk("t6_last_id", last_rec.id, 4);
    i_min_area = '0;

    // Frames arriving mid-sweep are dropped and counted.
    rand_stats();
    start_frame(40);
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(posedge clk);
      #1 i_frame_done = 1'b1;
      @(posedge clk);
      #1 i_frame_done = 1'b0;
    end
    wait_done(1'b0);
    chk("t4_dropped_3", o_frames_dropped, 3);
    rif.rec_ready = 1'b0;
    start_frame(40);
    for (int k = 0; k < 300; k++) begin
      i_frame_done = 1'b1;
      @(posedge clk);
      #1 i_frame_done = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("t4_dropped_sat", o_frames_dropped, 255);
    rif.rec_ready = 1'b1;
    wait_done(1'b0);
    chk("t4_dropped_hold", o_frames_dropped, 255);

    // Asynchronous reset mid-sweep with records queued.
    rand_stats();
    rif.rec_ready = 1'b0;
    start_frame(20);
    repeat (16) @(posedge clk);
    #2;
    chk("t5_queued_before", rif.rec_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", rif.rec_valid, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_obj_id", o_obj_id, 0);
    chk("t5_rst_dropped", o_frames_dropped, 0);
    exp_q.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    rif.rec_ready = 1'b1;
    @(posedge clk);
    #1;
    pc = pop_count;
    start_frame(5);
    wait_done(1'b0);
    chk("t5_resweep_count", pop_count - pc, 5);
    chk("t5_resweep_last", last_rec.id, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
